// File: rtl/target_group.sv
// -----------------------------------------------------------------------------
// target_group
//   Pool of NUM_TGT independent playfield targets. Each slot walks
//   IDLE -> ALIVE -> DYING -> IDLE. A spawn request claims the lowest-index
//   IDLE slot and places it at x=X_START in the lane chosen by din. ALIVE
//   targets scroll left by SPEED every tick. A shot moves a target to DYING,
//   where it stays for DYING_TICKS ticks. A target that scrolls off the left
//   edge returns to IDLE and pulses its escape bit.
//
// Optional feature macro: TARGET_SCORE_EN
//   When defined, adds a saturating kill score and a kill pulse.
//
// Ports
//   clk_100Hz        in   game tick clock
//   rst_n            in   asynchronous active-low reset
//   start            in   spawn request, sampled every cycle
//   din              in   lane for the spawn
//   shot             in   per-slot hit mask
//   x                out  slot i at [i*X_W +: X_W]
//   y                out  slot i at [i*Y_W +: Y_W]
//   state            out  2 bits per slot: 00 IDLE, 01 ALIVE, 10 DYING
//   animation_state  out  2 bits per slot: animation frame index
//   alive_cnt        out  number of ALIVE slots after the current update
//   spawn_drop       out  1-cycle pulse when a spawn is refused (pool full)
//   escape           out  1-cycle pulse per slot that left the screen
//   score            out  (TARGET_SCORE_EN) saturating kill count
//   kill             out  (TARGET_SCORE_EN) 1-cycle pulse when any slot dies
// -----------------------------------------------------------------------------
module target_group #(
    parameter int NUM_TGT     = 4,
    parameter int X_W         = 10,
    parameter int Y_W         = 9,
    parameter int LANE_W      = 3,
    parameter int X_START     = 640,
    parameter int Y_BASE      = 20,
    parameter int LANE_PITCH  = 60,
    parameter int SPEED       = 2,
    parameter int DYING_TICKS = 20,
    parameter int ANIM_DIV    = 10
) (
    input  logic                         clk_100Hz,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [LANE_W-1:0]            din,
    input  logic [NUM_TGT-1:0]           shot,
    output logic [NUM_TGT*X_W-1:0]       x,
    output logic [NUM_TGT*Y_W-1:0]       y,
    output logic [NUM_TGT*2-1:0]         state,
    output logic [NUM_TGT*2-1:0]         animation_state,
    output logic [$clog2(NUM_TGT+1)-1:0] alive_cnt,
    output logic                         spawn_drop,
    output logic [NUM_TGT-1:0]           escape
`ifdef TARGET_SCORE_EN
    ,
    output logic [15:0]                  score,
    output logic                         kill
`endif
);

    localparam int CW = $clog2(NUM_TGT + 1);
    // Counter widths kept at least 1 bit so ANIM_DIV=1 / DYING_TICKS=1 still build.
    localparam int FW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int DW = (DYING_TICKS > 1) ? $clog2(DYING_TICKS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ALIVE = 2'b01;
    localparam logic [1:0] ST_DYING = 2'b10;

    logic [NUM_TGT-1:0] idle_vec;
    logic [NUM_TGT:0]   idle_below;      // idle_below[i]: some slot < i is IDLE
    logic [NUM_TGT-1:0] spawn_sel;
    logic [NUM_TGT-1:0] alive_next_vec;
    logic [NUM_TGT-1:0] esc_next_vec;
    logic [Y_W-1:0]     lane_y;
    logic [CW-1:0]      alive_cnt_next;

    // Lane position, wrapped to Y_W bits like the hardware register holding it.
    assign lane_y = Y_W'(Y_BASE) + Y_W'(din) * Y_W'(LANE_PITCH);

    assign idle_below[0] = 1'b0;

`ifdef TARGET_SCORE_EN
    logic [NUM_TGT-1:0] die_vec;
    logic [CW-1:0]      kill_count;
    logic [16:0]        score_sum;
`endif

    generate
        for (genvar gi = 0; gi < NUM_TGT; gi++) begin : g_slot
            logic [1:0]     st_reg,    st_next;
            logic [X_W-1:0] x_reg,     x_next;
            logic [Y_W-1:0] y_reg,     y_next;
            logic [FW-1:0]  frame_reg, frame_next;
            logic [1:0]     anim_reg,  anim_next;
            logic [DW-1:0]  dcnt_reg,  dcnt_next;
            logic           esc_next;

            // Spawn selection uses the pre-update state, so a slot freed this
            // cycle only becomes a candidate on the next one.
            assign idle_vec[gi]       = (st_reg == ST_IDLE);
            assign idle_below[gi + 1] = idle_below[gi] | idle_vec[gi];
            assign spawn_sel[gi]      = start & idle_vec[gi] & ~idle_below[gi];
            assign alive_next_vec[gi] = (st_next == ST_ALIVE);
            assign esc_next_vec[gi]   = esc_next;
`ifdef TARGET_SCORE_EN
            assign die_vec[gi]        = (st_reg == ST_ALIVE) & shot[gi];
`endif

            // State register
            always_ff @(posedge clk_100Hz or negedge rst_n) begin
                if (!rst_n) begin
                    st_reg <= ST_IDLE;
                end else begin
                    st_reg <= st_next;
                end
            end

            // Next-state logic; a shot outranks the off-screen condition.
            always_comb begin
                st_next = st_reg;
                case (st_reg)
                    ST_IDLE: begin
                        if (spawn_sel[gi]) st_next = ST_ALIVE;
                    end
                    ST_ALIVE: begin
                        if (shot[gi])                    st_next = ST_DYING;
                        else if (x_reg < X_W'(SPEED))    st_next = ST_IDLE;
                    end
                    ST_DYING: begin
                        if (dcnt_reg == '0) st_next = ST_IDLE;
                    end
                    default: st_next = ST_IDLE;
                endcase
            end

            // Output / datapath logic: next values of the registered outputs.
            always_comb begin
                x_next     = x_reg;
                y_next     = y_reg;
                frame_next = frame_reg;
                anim_next  = anim_reg;
                dcnt_next  = dcnt_reg;
                esc_next   = 1'b0;
                case (st_reg)
                    ST_IDLE: begin
                        anim_next = 2'd0;
                        if (spawn_sel[gi]) begin
                            x_next     = X_W'(X_START);
                            y_next     = lane_y;
                            frame_next = '0;
                        end
                    end
                    ST_ALIVE: begin
                        if (shot[gi]) begin
                            // Position freezes where the target was hit.
                            dcnt_next = DW'(DYING_TICKS - 1);
                            anim_next = 2'd3;
                        end else if (x_reg < X_W'(SPEED)) begin
                            esc_next  = 1'b1;
                            anim_next = 2'd0;
                        end else begin
                            x_next = x_reg - X_W'(SPEED);
                            if (frame_reg == FW'(ANIM_DIV - 1)) begin
                                frame_next = '0;
                                anim_next  = (anim_reg == 2'd2) ? 2'd0 : anim_reg + 2'd1;
                            end else begin
                                frame_next = frame_reg + FW'(1);
                            end
                        end
                    end
                    ST_DYING: begin
                        if (dcnt_reg == '0) begin
                            anim_next = 2'd0;
                        end else begin
                            anim_next = 2'd3;
                            dcnt_next = dcnt_reg - DW'(1);
                        end
                    end
                    default: begin
                        anim_next = 2'd0;
                    end
                endcase
            end

            always_ff @(posedge clk_100Hz or negedge rst_n) begin
                if (!rst_n) begin
                    x_reg     <= '0;
                    y_reg     <= '0;
                    frame_reg <= '0;
                    anim_reg  <= '0;
                    dcnt_reg  <= '0;
                end else begin
                    x_reg     <= x_next;
                    y_reg     <= y_next;
                    frame_reg <= frame_next;
                    anim_reg  <= anim_next;
                    dcnt_reg  <= dcnt_next;
                end
            end

            assign x[gi*X_W +: X_W]         = x_reg;
            assign y[gi*Y_W +: Y_W]         = y_reg;
            assign state[gi*2 +: 2]         = st_reg;
            assign animation_state[gi*2 +: 2] = anim_reg;
        end
    endgenerate

    // Count of slots that will be ALIVE after this edge.
    always_comb begin
        alive_cnt_next = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            alive_cnt_next = alive_cnt_next + CW'(alive_next_vec[i]);
        end
    end

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            alive_cnt  <= '0;
            spawn_drop <= 1'b0;
            escape     <= '0;
        end else begin
            alive_cnt  <= alive_cnt_next;
            spawn_drop <= start & ~idle_below[NUM_TGT];
            escape     <= esc_next_vec;
        end
    end

`ifdef TARGET_SCORE_EN
    always_comb begin
        kill_count = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            kill_count = kill_count + CW'(die_vec[i]);
        end
    end

    assign score_sum = {1'b0, score} + 17'(kill_count);

    always_ff @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            score <= '0;
            kill  <= 1'b0;
        end else begin
            score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            kill  <= |die_vec;
        end
    end
`endif

endmodule

// File: tb/tb_target_group.sv
// -----------------------------------------------------------------------------
// tb_target_group
//   Directed bench for target_group. A behavioural pool model (per-slot
//   lifecycle, ages in ticks, plain arithmetic) advances on each clock edge;
//   a compare process checks every DUT output against it on each falling
//   edge. The main sequence adds hand-computed literal checks at key points.
// -----------------------------------------------------------------------------
module tb_target_group;

    localparam int N   = 4;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int X0  = 640;
    localparam int YB  = 20;
    localparam int LP  = 60;
    localparam int SPD = 2;
    localparam int DT  = 20;
    localparam int AD  = 10;

    logic              clk_100Hz = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        din;
    logic [N-1:0]      shot;
    logic [N*XW-1:0]   x;
    logic [N*YW-1:0]   y;
    logic [N*2-1:0]    state;
    logic [N*2-1:0]    animation_state;
    logic [2:0]        alive_cnt;
    logic              spawn_drop;
    logic [N-1:0]      escape;
`ifdef TARGET_SCORE_EN
    logic [15:0]       score;
    logic              kill;
`endif

    target_group dut (
        .clk_100Hz       (clk_100Hz),
        .rst_n           (rst_n),
        .start           (start),
        .din             (din),
        .shot            (shot),
        .x               (x),
        .y               (y),
        .state           (state),
        .animation_state (animation_state),
        .alive_cnt       (alive_cnt),
        .spawn_drop      (spawn_drop),
        .escape          (escape)
`ifdef TARGET_SCORE_EN
        ,
        .score           (score),
        .kill            (kill)
`endif
    );

    always #5 clk_100Hz = ~clk_100Hz;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 alive, 2 dying (the output encoding)
    int m_st[N], m_x[N], m_y[N], m_age[N], m_dage[N];
    int m_alive, m_drop, m_esc, m_kill, m_score;

    function automatic int m_anim(input int i);
        if (m_st[i] == 1) return (m_age[i] / AD) % 3;
        if (m_st[i] == 2) return 3;
        return 0;
    endfunction

    always @(posedge clk_100Hz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_age[i] = 0; m_dage[i] = 0;
            end
            m_alive = 0; m_drop = 0; m_esc = 0; m_kill = 0; m_score = 0;
        end else begin
            int first;
            int kills;
            first = -1;
            for (int i = 0; i < N; i++) if (m_st[i] == 0 && first < 0) first = i;
            m_esc = 0;
            kills = 0;
            for (int i = 0; i < N; i++) begin
                case (m_st[i])
                    1: begin
                        if (shot[i]) begin
                            m_st[i] = 2; m_dage[i] = 1; kills++;
                        end else if (m_x[i] < SPD) begin
                            m_st[i] = 0; m_esc = m_esc | (1 << i);
                        end else begin
                            m_x[i] = m_x[i] - SPD; m_age[i]++;
                        end
                    end
                    2: begin
                        if (m_dage[i] == DT) m_st[i] = 0;
                        else m_dage[i]++;
                    end
                    default: begin
                        if (start && i == first) begin
                            m_st[i] = 1; m_x[i] = X0;
                            m_y[i] = (YB + int'(din) * LP) % (1 << YW);
                            m_age[i] = 0;
                        end
                    end
                endcase
            end
            m_drop  = (start && first < 0) ? 1 : 0;
            m_alive = 0;
            for (int i = 0; i < N; i++) if (m_st[i] == 1) m_alive++;
            m_kill  = (kills > 0) ? 1 : 0;
            m_score = (m_score + kills > 65535) ? 65535 : m_score + kills;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_100Hz) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("state[%0d]", i), int'(state[i*2 +: 2]), m_st[i]);
            check($sformatf("x[%0d]", i), int'(x[i*XW +: XW]), m_x[i]);
            check($sformatf("y[%0d]", i), int'(y[i*YW +: YW]), m_y[i]);
            check($sformatf("anim[%0d]", i), int'(animation_state[i*2 +: 2]), m_anim(i));
        end
        check("escape", int'(escape), m_esc);
        check("spawn_drop", int'(spawn_drop), m_drop);
        check("alive_cnt", int'(alive_cnt), m_alive);
`ifdef TARGET_SCORE_EN
        check("score", int'(score), m_score);
        check("kill", int'(kill), m_kill);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic [2:0] d, input logic [N-1:0] sh);
        start = s; din = d; shot = sh;
        @(negedge clk_100Hz);
        $display("[TB] t=%0t start=%0b din=%0d shot=%b state=%b alive=%0d drop=%0b esc=%b",
                 $time, s, d, sh, state, alive_cnt, spawn_drop, escape);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_n = 1'b0; start = 1'b0; din = '0; shot = '0;
        @(negedge clk_100Hz);
        @(negedge clk_100Hz);
        check("rst_state", int'(state), 0);
        check("rst_alive", int'(alive_cnt), 0);
        rst_n = 1'b1;

        // 1: spawn in lane 3, scroll, animation step
        cyc(1, 3'd3, '0);
        check("t1_state0", int'(state[1:0]), 1);
        check("t1_x0", int'(x[9:0]), 640);
        check("t1_y0", int'(y[8:0]), 200);
        cyc(0, 3'd0, '0);
        check("t1_x0_move", int'(x[9:0]), 638);
        repeat (8) cyc(0, 3'd0, '0);
        check("t1_anim_pre", int'(animation_state[1:0]), 0);
        cyc(0, 3'd0, '0);
        check("t1_anim_step", int'(animation_state[1:0]), 1);
        check("t1_x0_620", int'(x[9:0]), 620);

        // 2: scroll off the left edge
        repeat (310) cyc(0, 3'd0, '0);
        check("t2_x0_zero", int'(x[9:0]), 0);
        check("t2_still_alive", int'(state[1:0]), 1);
        cyc(0, 3'd0, '0);
        check("t2_idle", int'(state[1:0]), 0);
        check("t2_escape", int'(escape), 1);
        check("t2_alive_cnt", int'(alive_cnt), 0);
        cyc(0, 3'd0, '0);
        check("t2_escape_pulse", int'(escape), 0);

        // 3: fill the pool, then overflow
        repeat (4) cyc(1, 3'd1, '0);
        check("t3_alive4", int'(alive_cnt), 4);
        check("t3_y3", int'(y[35:27]), 80);
        check("t3_drop_pre", int'(spawn_drop), 0);
        cyc(1, 3'd1, '0);
        check("t3_drop", int'(spawn_drop), 1);
        check("t3_states", int'(state), 8'b01010101);

        // 4: kill slot 2, spawns during DYING must not touch it
        cyc(0, 3'd0, 4'b0100);
        check("t4_dying", int'(state[5:4]), 2);
        check("t4_anim3", int'(animation_state[5:4]), 3);
        check("t4_x_frozen", int'(x[29:20]), 636);
        cyc(1, 3'd5, '0);
        check("t4_drop", int'(spawn_drop), 1);
        check("t4_y_kept", int'(y[26:18]), 80);
        repeat (18) cyc(0, 3'd0, '0);
        check("t4_dying_last", int'(state[5:4]), 2);
        cyc(0, 3'd0, '0);
        check("t4_idle", int'(state[5:4]), 0);
        check("t4_anim0", int'(animation_state[5:4]), 0);

        // 5: shot and escape condition together (slot 0 at x=0): shot wins
        guard = 0;
        while ((m_st[0] != 1 || m_x[0] != 0) && guard < 400) begin
            cyc(0, 3'd0, '0);
            guard++;
        end
        check("t5_reach_x0", (guard < 400) ? 1 : 0, 1);
        cyc(0, 3'd0, 4'b0001);
        check("t5_dying", int'(state[1:0]), 2);
        check("t5_no_escape", int'(escape[0]), 0);
`ifdef TARGET_SCORE_EN
        check("t5_kill", int'(kill), 1);
        check("t5_score", int'(score), 2);
`endif

        // 6: async reset mid-DYING with three slots active
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_state", int'(state), 0);
        check("t6_x", int'(x), 0);
        check("t6_y", int'(y), 0);
        check("t6_anim", int'(animation_state), 0);
        check("t6_alive", int'(alive_cnt), 0);
        check("t6_escape", int'(escape), 0);
        @(negedge clk_100Hz);
        @(negedge clk_100Hz);
        rst_n = 1'b1;
        cyc(1, 3'd5, '0);
        check("t6_slot0", int'(state), 8'b00000001);
        check("t6_y0", int'(y[8:0]), 320);
        cyc(1, 3'd7, '0);
        check("t6_y1", int'(y[17:9]), 440);
        check("t6_alive2", int'(alive_cnt), 2);
        cyc(0, 3'd0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
